// File: rtl/inverse_drain.sv
// Ping-pong capture of a lower-triangle inverse, replayed as a mirrored N*N row-major stream.
// Latency: the first element is valid the cycle after the last triangle word is accepted (drain bank idle).
// Backpressure: in_ready drops only while both banks hold unfinished results; out_ready stalls hold the output.
module inverse_drain #(
   parameter int N = 6,
   parameter int W = 36
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_valid,
   input  logic         in_first,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [2:0]   out_row,
   output logic [2:0]   out_col,
   output logic         out_last,
   output logic         sync_err
);

   localparam int T = N * (N + 1) / 2;
   localparam int IW = (T > 1) ? $clog2(T) : 1;
   localparam logic [2:0] LAST = 3'(N - 1);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

   bank_st_t       st [2];
   bank_st_t       st_n [2];
   logic           fill_sel, fill_sel_n;
   logic           drain_sel, drain_sel_n;
   logic [2:0]     wr_r, wr_c, wr_r_n, wr_c_n;
   logic [2:0]     rd_r, rd_c, rd_r_n, rd_c_n;
   logic [2:0]     cur_r, cur_c;
   logic [2:0]     rd_hi, rd_lo;
   logic           sync_err_n;
   logic           wr_en;
   logic [IW-1:0]  widx;
   logic           acc, xfer, wr_zero;
   logic [W-1:0]   mem [2][T];

   // Packed lower-triangle position of element (r,c) with c <= r.
   function automatic logic [IW-1:0] tri_idx(input logic [2:0] r, input logic [2:0] c);
      logic [6:0] rw;
      logic [6:0] sum;
      rw  = {4'd0, r};
      sum = ((rw * (rw + 7'd1)) >> 1) + {4'd0, c};
      return sum[IW-1:0];
   endfunction

   assign acc     = in_valid && in_ready && en;
   assign xfer    = out_valid && out_ready && en;
   assign wr_zero = (wr_r == 3'd0) && (wr_c == 3'd0);

   assign in_ready  = (st[fill_sel] == EMPTY) || (st[fill_sel] == FILLING);
   assign out_valid = (st[drain_sel] == FULL) || (st[drain_sel] == DRAINING);
   assign out_row   = rd_r;
   assign out_col   = rd_c;
   assign out_last  = out_valid && (rd_r == LAST) && (rd_c == LAST);
   assign rd_hi     = (rd_r > rd_c) ? rd_r : rd_c;
   assign rd_lo     = (rd_r > rd_c) ? rd_c : rd_r;
   // Gated so the output reads zero while nothing is being drained (storage is never cleared).
   assign out_data  = out_valid ? mem[drain_sel][tri_idx(rd_hi, rd_lo)] : '0;

   // Next-state: fill side (write pointer, resync) and drain side (read pointer) of the bank FSMs.
   always_comb begin
      st_n        = st;
      fill_sel_n  = fill_sel;
      drain_sel_n = drain_sel;
      wr_r_n      = wr_r;
      wr_c_n      = wr_c;
      rd_r_n      = rd_r;
      rd_c_n      = rd_c;
      sync_err_n  = 1'b0;
      wr_en       = 1'b0;
      widx        = tri_idx(wr_r, wr_c);
      cur_r       = wr_r;
      cur_c       = wr_c;

      if (acc) begin
         if (!in_first && wr_zero) begin
            // Stray word outside a frame: drop it.
            sync_err_n = 1'b1;
         end else begin
            wr_en = 1'b1;
            if (in_first) begin
               // A new frame always lands at (0,0); a partial frame in progress is abandoned.
               cur_r      = 3'd0;
               cur_c      = 3'd0;
               widx       = '0;
               sync_err_n = !wr_zero;
            end
            if ((cur_r == LAST) && (cur_c == LAST)) begin
               st_n[fill_sel] = FULL;
               fill_sel_n     = !fill_sel;
               wr_r_n         = 3'd0;
               wr_c_n         = 3'd0;
            end else begin
               st_n[fill_sel] = FILLING;
               if (cur_c == cur_r) begin
                  wr_r_n = cur_r + 3'd1;
                  wr_c_n = 3'd0;
               end else begin
                  wr_r_n = cur_r;
                  wr_c_n = cur_c + 3'd1;
               end
            end
         end
      end

      if (xfer) begin
         if (out_last) begin
            st_n[drain_sel] = EMPTY;
            drain_sel_n     = !drain_sel;
            rd_r_n          = 3'd0;
            rd_c_n          = 3'd0;
         end else begin
            st_n[drain_sel] = DRAINING;
            if (rd_c == LAST) begin
               rd_r_n = rd_r + 3'd1;
               rd_c_n = 3'd0;
            end else begin
               rd_c_n = rd_c + 3'd1;
            end
         end
      end else if (en && (st[drain_sel] == FULL)) begin
         st_n[drain_sel] = DRAINING;
      end
   end

   // State register; en=0 freezes everything except the single-cycle sync_err pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st[0]     <= EMPTY;
         st[1]     <= EMPTY;
         fill_sel  <= 1'b0;
         drain_sel <= 1'b0;
         wr_r      <= 3'd0;
         wr_c      <= 3'd0;
         rd_r      <= 3'd0;
         rd_c      <= 3'd0;
         sync_err  <= 1'b0;
      end else begin
         st[0]     <= st_n[0];
         st[1]     <= st_n[1];
         fill_sel  <= fill_sel_n;
         drain_sel <= drain_sel_n;
         wr_r      <= wr_r_n;
         wr_c      <= wr_c_n;
         rd_r      <= rd_r_n;
         rd_c      <= rd_c_n;
         sync_err  <= sync_err_n;
      end
   end

   // Bank storage write; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[fill_sel][widx] <= in_data;
      end
   end

endmodule

// File: tb/tb_inverse_drain.sv
// Scoreboard bench for inverse_drain: expected mirrored matrices queued at stimulus time.
// Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
// Covers reset, ping-pong backpressure, stalls, resync, enable freeze and reset mid-drain.
module tb_inverse_drain;

   localparam int N = 6;
   localparam int W = 36;
   localparam int T = N * (N + 1) / 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_first = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic [2:0]   out_row, out_col;
   logic         out_last;
   logic         sync_err;

   typedef struct {
      logic [W-1:0] d;
      logic [2:0]   r;
      logic [2:0]   c;
      logic         l;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;
   int xcnt = 0;
   int lastcnt = 0;
   int serr = 0;
   int vcyc = 0;
   int rmode = 0;
   logic         held_vld = 1'b0;
   logic [W-1:0] hd;
   logic [2:0]   hr, hc;

   inverse_drain #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .in_valid(in_valid), .in_first(in_first), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Consumer ready pattern: 0 always ready, 1 never ready, 2 alternate.
   always @(posedge clk) begin
      #1;
      case (rmode)
         0: out_ready = 1'b1;
         1: out_ready = 1'b0;
         default: out_ready = ~out_ready;
      endcase
   end

   // Output monitor: scoreboard compare on transfer, stability check while stalled.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) vcyc++;
         if (out_valid && held_vld) begin
            chk("stall_data", 64'(out_data), 64'(hd));
            chk("stall_row", 64'(out_row), 64'(hr));
            chk("stall_col", 64'(out_col), 64'(hc));
         end
         held_vld = 1'b0;
         if (out_valid && en) begin
            if (out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_output", 64'(out_data), 64'hdead);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("out_data", 64'(out_data), 64'(e.d));
                  chk("out_row", 64'(out_row), 64'(e.r));
                  chk("out_col", 64'(out_col), 64'(e.c));
                  chk("out_last", 64'(out_last), 64'(e.l));
               end
               xcnt++;
               if (out_last) lastcnt++;
            end else begin
               held_vld = 1'b1;
               hd = out_data;
               hr = out_row;
               hc = out_col;
            end
         end
         if (sync_err) serr++;
      end else begin
         held_vld = 1'b0;
      end
   end

   // Queue the full mirrored matrix of a frame whose k-th triangle word is base+k.
   task automatic push_frame(input int base);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            exp_t e;
            int m, n;
            m = (i > j) ? i : j;
            n = (i > j) ? j : i;
            e.d = W'(base + m * (m + 1) / 2 + n + 1);
            e.r = 3'(i);
            e.c = 3'(j);
            e.l = (i == N - 1) && (j == N - 1);
            q.push_back(e);
         end
      end
   endtask

   task automatic send_word(input int val, input logic first);
      int t;
      in_valid = 1'b1;
      in_first = first;
      in_data  = W'(val);
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready && en) break;
         t++;
         if (t > 3000) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic send_frame(input int base);
      push_frame(base);
      for (int k = 1; k <= T; k++) send_word(base + k, k == 1);
   endtask

   task automatic wait_empty();
      int t;
      t = 0;
      while (q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_xcnt(input int target);
      int t;
      t = 0;
      while (xcnt < target && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (xcnt < target) chk("xfer_timeout", 64'(xcnt), 64'(target));
   endtask

   initial begin
      int x0, s0, v0, t;

      // Reset values
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_rowcol", 64'({out_row, out_col}), 64'd0);
      chk("rst_last_err", 64'({out_last, sync_err}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame 1..21, free-running consumer
      send_frame(0);
      wait_empty();
      chk("frame1_xfers", 64'(xcnt), 64'd36);
      chk("frame1_last_once", 64'(lastcnt), 64'd1);

      // Both banks filled with consumer stalled
      rmode = 1;
      send_frame(100);
      send_frame(200);
      @(negedge clk);
      chk("in_ready_both_full", 64'(in_ready), 64'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("in_ready_held_off", 64'(in_ready), 64'd0);
      rmode = 0;
      x0 = xcnt;
      t = 0;
      while (!in_ready && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("ready_after_36", 64'(xcnt - x0), 64'd36);
      send_frame(300);
      wait_empty();

      // Alternating consumer ready
      rmode = 2;
      x0 = xcnt;
      v0 = vcyc;
      send_frame(400);
      wait_empty();
      chk("toggle_xfers", 64'(xcnt - x0), 64'd36);
      chk("toggle_cycles_le72", 64'((vcyc - v0) <= 72 && (vcyc - v0) >= 71), 64'd1);
      rmode = 0;
      @(posedge clk);
      #1;

      // Frame restart at word 10; only the new frame may appear
      s0 = serr;
      for (int k = 1; k <= 9; k++) send_word(500 + k, k == 1);
      send_frame(600);
      wait_empty();
      chk("restart_sync_err", 64'(serr - s0), 64'd1);

      // Stray word while idle is dropped
      s0 = serr;
      send_word(77, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("stray_sync_err", 64'(serr - s0), 64'd1);
      chk("stray_no_output", 64'(out_valid), 64'd0);
      send_frame(700);
      wait_empty();

      // Enable freeze at input word 7 and at output 20
      x0 = xcnt;
      push_frame(800);
      for (int k = 1; k <= T; k++) begin
         if (k == 7) begin
            en = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            en = 1'b1;
         end
         send_word(800 + k, k == 1);
      end
      wait_xcnt(x0 + 20);
      en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("en_freeze_xfers", 64'(xcnt - x0), 64'd20);
      chk("en_freeze_valid", 64'(out_valid), 64'd1);
      en = 1'b1;
      wait_empty();

      // Reset during drain
      x0 = xcnt;
      send_frame(900);
      wait_xcnt(x0 + 12);
      rst_n = 1'b0;
      #1;
      chk("rst_drain_out_valid", 64'(out_valid), 64'd0);
      chk("rst_drain_rowcol", 64'({out_row, out_col}), 64'd0);
      chk("rst_drain_in_ready", 64'(in_ready), 64'd1);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_frame(1000);
      wait_empty();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
